// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - bimodal 2-bit counter direction predictor with mispredict flush and hit/miss statistics
module branch_predictor #(
  parameter int         IDX_BITS   = 4,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int         CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      q_pc,
  input  logic             q_is_branch,
  output logic             guess,
  input  logic             r_valid,
  input  logic [31:0]      r_pc,
  input  logic             r_taken,
  input  logic             r_guess,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam int ENTRIES = 1 << IDX_BITS;

  logic [1:0]          cnt_tbl [ENTRIES];
  logic [IDX_BITS-1:0] q_idx;
  logic [IDX_BITS-1:0] r_idx;
  logic [1:0]          r_cur;
  logic [1:0]          r_next;

  assign q_idx = q_pc[IDX_BITS+1:2];
  assign r_idx = r_pc[IDX_BITS+1:2];

  // Ternary keeps an unknown q_pc from leaking into guess when no branch is queried.
  assign guess = q_is_branch ? cnt_tbl[q_idx][1] : 1'b0;

  // Decision trusts the carried guess, never the (possibly updated) table.
  assign flush = r_valid & ~rst & (r_taken ^ r_guess);

  assign r_cur = cnt_tbl[r_idx];

  always_comb begin
    r_next = r_cur;
    if (r_taken) begin
      if (r_cur != 2'b11) r_next = r_cur + 2'b01;
    end else begin
      if (r_cur != 2'b00) r_next = r_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) cnt_tbl[i] <= INIT_STATE;
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (r_valid) begin
      cnt_tbl[r_idx] <= r_next;
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_W'(1);
      if (flush && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Upper and byte-offset PC bits do not select an entry.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{q_pc[31:IDX_BITS+2], q_pc[1:0], r_pc[31:IDX_BITS+2], r_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed self-checking bench for branch_predictor
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] q_pc;
  logic        q_is_branch;
  logic        guess;
  logic        r_valid;
  logic [31:0] r_pc;
  logic        r_taken;
  logic        r_guess;
  logic        flush;
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  logic [31:0] q4_pc;
  logic        q4_is_branch;
  logic        guess4;
  logic        r4_valid;
  logic [31:0] r4_pc;
  logic        r4_taken;
  logic        r4_guess;
  logic        flush4;
  logic [3:0]  br4_cnt;
  logic [3:0]  miss4_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .q_pc(q_pc), .q_is_branch(q_is_branch), .guess(guess),
    .r_valid(r_valid), .r_pc(r_pc), .r_taken(r_taken), .r_guess(r_guess),
    .flush(flush), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
  );

  branch_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .q_pc(q4_pc), .q_is_branch(q4_is_branch), .guess(guess4),
    .r_valid(r4_valid), .r_pc(r4_pc), .r_taken(r4_taken), .r_guess(r4_guess),
    .flush(flush4), .br_cnt(br4_cnt), .miss_cnt(miss4_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic g);
    r_valid = 1'b1; r_pc = pc; r_taken = taken; r_guess = g;
  endtask

  task automatic query(input logic [31:0] pc);
    q_pc = pc; q_is_branch = 1'b1; #1;
  endtask

  initial begin
    rst = 1'b1; q_pc = 32'h0; q_is_branch = 1'b0;
    r_valid = 1'b0; r_pc = 32'h0; r_taken = 1'b0; r_guess = 1'b0;
    q4_pc = 32'h0; q4_is_branch = 1'b0;
    r4_valid = 1'b0; r4_pc = 32'h0; r4_taken = 1'b0; r4_guess = 1'b0;
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_br_cnt", br_cnt, 32'd0);
    check("rst_miss_cnt", miss_cnt, 32'd0);
    query(32'h40);
    check("rst_guess_40", {31'd0, guess}, 32'd0);
    q_is_branch = 1'b0; q_pc = 'x; #1;
    check("nobranch_x_pc", {31'd0, guess}, 32'd0);

    // Two mispredicted takens: 01 -> 10 -> 11
    query(32'h40);
    resolve(32'h40, 1'b1, 1'b0); #1;
    check("flush_1st", {31'd0, flush}, 32'd1);
    check("guess_pre_1st", {31'd0, guess}, 32'd0);
    tick();
    check("flush_2nd", {31'd0, flush}, 32'd1);
    check("guess_after_10", {31'd0, guess}, 32'd1);
    tick();
    r_valid = 1'b0; #1;
    check("br_cnt_2", br_cnt, 32'd2);
    check("miss_cnt_2", miss_cnt, 32'd2);

    // Correct taken at 11 stays 11, no miss
    resolve(32'h40, 1'b1, 1'b1); #1;
    check("flush_correct", {31'd0, flush}, 32'd0);
    tick();
    r_valid = 1'b0; #1;
    check("br_cnt_3", br_cnt, 32'd3);
    check("miss_cnt_3", miss_cnt, 32'd2);

    // Not-taken from 11 -> 10 (guess 1) -> 01 (guess 0)
    resolve(32'h40, 1'b0, 1'b1); #1;
    check("flush_nt_1", {31'd0, flush}, 32'd1);
    tick();
    check("guess_sat_10", {31'd0, guess}, 32'd1);
    check("flush_nt_2", {31'd0, flush}, 32'd1);
    tick();
    r_valid = 1'b0; #1;
    check("guess_01", {31'd0, guess}, 32'd0);
    check("br_cnt_5", br_cnt, 32'd5);
    check("miss_cnt_4", miss_cnt, 32'd4);

    // Alias 0x80 shares entry with 0x40; low PC bits ignored
    query(32'h80);
    check("alias_guess_0", {31'd0, guess}, 32'd0);
    resolve(32'h80, 1'b1, 1'b0);
    tick();
    r_valid = 1'b0;
    query(32'h40);
    check("alias_guess_40", {31'd0, guess}, 32'd1);
    query(32'h43);
    check("low_bits_ignored", {31'd0, guess}, 32'd1);

    // Same-cycle query and update: no bypass
    query(32'h44);
    resolve(32'h44, 1'b1, 1'b0); #1;
    check("same_cycle_guess", {31'd0, guess}, 32'd0);
    tick();
    r_valid = 1'b0; #1;
    check("next_cycle_guess", {31'd0, guess}, 32'd1);
    check("br_cnt_7", br_cnt, 32'd7);
    check("miss_cnt_6", miss_cnt, 32'd6);

    // Floor saturation at 0x4C: 01 -> 00 -> 00, then taken -> 01 -> 10
    resolve(32'h4C, 1'b0, 1'b0);
    tick(); tick();
    resolve(32'h4C, 1'b1, 1'b0);
    tick();
    r_valid = 1'b0;
    query(32'h4C);
    check("floor_01_guess", {31'd0, guess}, 32'd0);
    resolve(32'h4C, 1'b1, 1'b0);
    tick();
    r_valid = 1'b0; #1;
    check("floor_10_guess", {31'd0, guess}, 32'd1);
    check("br_cnt_11", br_cnt, 32'd11);
    check("miss_cnt_8", miss_cnt, 32'd8);

    // Statistics saturation on the 4-bit build
    r4_valid = 1'b1; r4_pc = 32'h40; r4_taken = 1'b1; r4_guess = 1'b0; #1;
    check("flush4", {31'd0, flush4}, 32'd1);
    check("guess4_idle", {31'd0, guess4}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("br4_full", {28'd0, br4_cnt}, 32'hF);
    check("miss4_full", {28'd0, miss4_cnt}, 32'hF);
    tick(); tick();
    r4_valid = 1'b0; #1;
    check("br4_sat", {28'd0, br4_cnt}, 32'hF);
    check("miss4_sat", {28'd0, miss4_cnt}, 32'hF);

    // Train 0x48 to 11, then reset with r_valid high
    resolve(32'h48, 1'b1, 1'b1);
    tick(); tick();
    r_valid = 1'b0;
    query(32'h48);
    check("trained_48", {31'd0, guess}, 32'd1);
    rst = 1'b1;
    resolve(32'h48, 1'b0, 1'b1); #1;
    check("flush_in_rst", {31'd0, flush}, 32'd0);
    tick();
    rst = 1'b0; r_valid = 1'b0;
    query(32'h48);
    check("post_rst_48", {31'd0, guess}, 32'd0);
    query(32'h44);
    check("post_rst_44", {31'd0, guess}, 32'd0);
    check("post_rst_br", br_cnt, 32'd0);
    check("post_rst_miss", miss_cnt, 32'd0);
    check("post_rst_br4", {28'd0, br4_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
